program_counter_stage: RTL

- First pipeline stage of the RISC-V core; owns the architectural fetch PC and presents it to the instruction cache and fetch stage.
- Consumes STALL_PROGRAME_COUNTER_STAGE from the hazard control unit and redirect requests (taken branch/jump) from the execution stage.
- Buffers a redirect that arrives while stalled so it is never lost, and counts issued fetches for performance monitoring.

---
 rtl/program_counter_stage_pkg.sv | 21 ++
 rtl/program_counter_stage_redirect_buffer.sv | 29 ++
 rtl/program_counter_stage.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/program_counter_stage_pkg.sv
// rtl/program_counter_stage_pkg.sv - shared state encodings and constants for the fetch PC stage
package program_counter_stage_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_e;

  localparam logic HIGH = 1'b1;
  localparam logic LOW  = 1'b0;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int          DEFAULT_PC_INCREMENT = 4;

  // Instructions are word aligned, so the two address LSBs must be zero.
  function automatic logic is_word_aligned(input logic [1:0] lsbs);
    return (lsbs == 2'b00);
  endfunction

endpackage

// File: rtl/program_counter_stage_redirect_buffer.sv
// rtl/program_counter_stage_redirect_buffer.sv - holds a redirect target that arrived while the stage could not advance
module program_counter_stage_redirect_buffer
  import program_counter_stage_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_target,
  input  logic                  clear,
  output logic                  pending_valid,
  output logic [ADDR_WIDTH-1:0] pending_target
);

  // Newest redirect overwrites any older one; load wins over clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_valid  <= LOW;
      pending_target <= '0;
    end else if (load) begin
      pending_valid  <= HIGH;
      pending_target <= load_target;
    end else if (clear) begin
      pending_valid  <= LOW;
    end
  end

endmodule

// File: rtl/program_counter_stage.sv
// rtl/program_counter_stage.sv - fetch PC owner with stall hold, redirect buffering and fetch counter (option: PC_MISALIGN_CHECK_EN)
module program_counter_stage
  import program_counter_stage_pkg::*;
#(
  parameter int                    ADDR_WIDTH   = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int                    PC_INCREMENT = DEFAULT_PC_INCREMENT,
  parameter int                    COUNT_WIDTH  = 32
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   STALL_PROGRAME_COUNTER_STAGE,
  input  logic                   BRANCH_TAKEN,
  input  logic [ADDR_WIDTH-1:0]  BRANCH_TARGET,
  output logic [ADDR_WIDTH-1:0]  PC,
  output logic                   PC_VALID,
  output logic                   FLUSH_FETCH,
  output logic [COUNT_WIDTH-1:0] FETCH_COUNT
`ifdef PC_MISALIGN_CHECK_EN
  ,
  output logic                   MISALIGNED_TARGET,
  output logic [ADDR_WIDTH-1:0]  MISALIGNED_ADDRESS
`endif
);

  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  pc_state_e             state;
  pc_state_e             state_next;
  logic                  advance;
  logic                  misaligned;
  logic                  redirect_req;
  logic                  capture;
  logic                  flush_next;
  logic                  pending_valid;
  logic [ADDR_WIDTH-1:0] pending_target;
  logic [ADDR_WIDTH-1:0] target_word;
  logic [ADDR_WIDTH-1:0] pc_next;

  assign target_word = BRANCH_TARGET & WORD_MASK;

`ifdef PC_MISALIGN_CHECK_EN
  assign misaligned = BRANCH_TAKEN && !is_word_aligned(BRANCH_TARGET[1:0]);
`else
  assign misaligned = LOW;
`endif

  assign redirect_req = BRANCH_TAKEN && !misaligned;
  // A redirect that cannot be applied now (boot cycle or stalled) is parked.
  assign capture      = redirect_req && !advance;

  program_counter_stage_redirect_buffer #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_redirect_buffer (
    .clk            (CLK),
    .rst            (RST),
    .load           (capture),
    .load_target    (target_word),
    .clear          (advance),
    .pending_valid  (pending_valid),
    .pending_target (pending_target)
  );

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next state, fetch-valid and advance decision; a release cycle out of HOLD advances like RUN.
  always_comb begin
    state_next = state;
    PC_VALID   = HIGH;
    advance    = LOW;
    case (state)
      BOOT: begin
        PC_VALID   = LOW;
        state_next = RUN;
      end
      RUN: begin
        if (STALL_PROGRAME_COUNTER_STAGE) begin
          state_next = HOLD;
        end else begin
          advance = HIGH;
        end
      end
      HOLD: begin
        if (!STALL_PROGRAME_COUNTER_STAGE) begin
          state_next = RUN;
          advance    = HIGH;
        end
      end
      default: begin
        PC_VALID   = LOW;
        state_next = BOOT;
      end
    endcase
  end

  // Next-PC select: live redirect, then parked redirect, then sequential step.
  always_comb begin
    pc_next    = PC;
    flush_next = LOW;
    if (advance) begin
      if (redirect_req) begin
        pc_next    = target_word;
        flush_next = HIGH;
      end else if (pending_valid) begin
        pc_next    = pending_target;
        flush_next = HIGH;
      end else begin
        pc_next = PC + ADDR_WIDTH'(PC_INCREMENT);
      end
    end
  end

  // PC, flush pulse and accepted-fetch counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      PC          <= RESET_VECTOR;
      FLUSH_FETCH <= LOW;
      FETCH_COUNT <= '0;
    end else begin
      PC          <= pc_next;
      FLUSH_FETCH <= flush_next;
      if (advance) begin
        FETCH_COUNT <= FETCH_COUNT + COUNT_WIDTH'(1);
      end
    end
  end

`ifdef PC_MISALIGN_CHECK_EN
  // Report rejected redirects and remember the last offending address.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      MISALIGNED_TARGET  <= LOW;
      MISALIGNED_ADDRESS <= '0;
    end else begin
      MISALIGNED_TARGET <= misaligned;
      if (misaligned) begin
        MISALIGNED_ADDRESS <= BRANCH_TARGET;
      end
    end
  end
`endif

endmodule
